// File: rtl/uart_pkg.sv
// Shared constants and rx state encoding for the UART receiver.
package uart_pkg;

  localparam int unsigned BAUD_CNT_MAX_DEFAULT = 5207;  // 50 MHz / 9600 baud
  localparam int unsigned DATA_W               = 8;
  localparam int unsigned BAUD_CNT_W           = 14;
  localparam int unsigned BIT_CNT_W            = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Metastability stage followed by the stable output stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, mid-bit sampling.
// Optional UART_RX_FRAME_ERR_EN adds the rx_frame_err port and stop-bit checking.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CNT_MAX = BAUD_CNT_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic              rx_frame_err
`endif
);

  localparam logic [BAUD_CNT_W-1:0] SAMPLE_PT = BAUD_CNT_W'(BAUD_CNT_MAX / 2);
  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(DATA_W - 1);

  rx_state_t             state, state_nxt;
  logic [BAUD_CNT_W-1:0] baud_cnt, baud_nxt;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_nxt;
  logic [DATA_W-1:0]     shift_reg, shift_nxt;
  logic [DATA_W-1:0]     data_nxt;
  logic                  valid_nxt;
  logic                  line;
  logic                  line_prev;
  logic                  sample_c;
`ifdef UART_RX_FRAME_ERR_EN
  logic                  ferr_nxt;
`endif

  uart_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (rx_in),
    .sync_out (line)
  );

  assign sample_c = (baud_cnt == SAMPLE_PT);

  // Next-state, counters, shifter and output pulses
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    data_nxt  = rx_data;
    valid_nxt = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_nxt  = 1'b0;
`endif

    if (state != IDLE) begin
      baud_nxt = (baud_cnt == BAUD_LAST) ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        baud_nxt = '0;
        // Start-bit edge is only looked for here, so mid-frame activity is ignored
        if (line_prev && !line) begin
          state_nxt = START;
        end
      end
      START: begin
        if (sample_c) begin
          if (line) begin
            state_nxt = IDLE;
            baud_nxt  = '0;
          end else begin
            state_nxt = DATA;
            bit_nxt   = '0;
          end
        end
      end
      DATA: begin
        if (sample_c) begin
          shift_nxt = {line, shift_reg[DATA_W-1:1]};
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        // Leave mid stop bit so a following start edge is caught
        if (sample_c) begin
          state_nxt = IDLE;
          baud_nxt  = '0;
`ifdef UART_RX_FRAME_ERR_EN
          if (line) begin
            data_nxt  = shift_reg;
            valid_nxt = 1'b1;
          end else begin
            ferr_nxt  = 1'b1;
          end
`else
          data_nxt  = shift_reg;
          valid_nxt = 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      line_prev    <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      rx_frame_err <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      baud_cnt     <= baud_nxt;
      bit_cnt      <= bit_nxt;
      shift_reg    <= shift_nxt;
      line_prev    <= line;
      rx_data      <= data_nxt;
      rx_valid     <= valid_nxt;
`ifdef UART_RX_FRAME_ERR_EN
      rx_frame_err <= ferr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a fast instance (56 clocks/bit) for the functional scenarios
// and a slow instance (5207 clocks/bit) for the default-rate frame.
module tb_uart_rx;

  localparam int unsigned M_FAST = 56;
  localparam int unsigned M_SLOW = 5207;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_fast;
  logic       rx_slow;
  logic [7:0] data_fast;
  logic [7:0] data_slow;
  logic       valid_fast;
  logic       valid_slow;
`ifdef UART_RX_FRAME_ERR_EN
  logic       ferr_fast;
  logic       ferr_slow;
`endif

  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned n_fail = 0;

  logic [7:0] fq_data[$];
  int         fq_cyc[$];
  logic [7:0] sq_data[$];
  int         sq_cyc[$];
  int unsigned ferr_cnt_fast = 0;
  int unsigned dbl_cnt = 0;
  logic        prev_vf = 1'b0;
  logic        prev_vs = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.BAUD_CNT_MAX(M_FAST)) dut_fast (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_in        (rx_fast),
    .rx_data      (data_fast),
    .rx_valid     (valid_fast)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .rx_frame_err (ferr_fast)
`endif
  );

  uart_rx #(.BAUD_CNT_MAX(M_SLOW)) dut_slow (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_in        (rx_slow),
    .rx_data      (data_slow),
    .rx_valid     (valid_slow)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .rx_frame_err (ferr_slow)
`endif
  );

  always @(posedge clk) cyc++;

  // Record every output pulse with its cycle stamp
  always @(negedge clk) begin
    if (valid_fast) begin
      fq_data.push_back(data_fast);
      fq_cyc.push_back(int'(cyc));
    end
    if (valid_slow) begin
      sq_data.push_back(data_slow);
      sq_cyc.push_back(int'(cyc));
    end
    if ((valid_fast && prev_vf) || (valid_slow && prev_vs)) dbl_cnt++;
    prev_vf = valid_fast;
    prev_vs = valid_slow;
`ifdef UART_RX_FRAME_ERR_EN
    if (ferr_fast) ferr_cnt_fast++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fq_at(input int idx);
    if (idx < fq_data.size()) return fq_data[idx];
    return 8'hxx;
  endfunction

  function automatic int fc_at(input int idx);
    if (idx < fq_cyc.size()) return fq_cyc[idx];
    return -100000;
  endfunction

  // Pulse expected 9.5 bit times after the start edge, +/- 4 clocks
  function automatic logic lat_ok(input int lat, input int m);
    return (2 * lat >= 19 * m - 8) && (2 * lat <= 19 * m + 8);
  endfunction

  // Drive one frame; called and returns on a falling clock edge
  task automatic send_frame(input bit slow, input logic [7:0] b, input logic stop_bit,
                            output int t0);
    int unsigned m;
    logic [9:0]  bits;
    m    = slow ? M_SLOW : M_FAST;
    bits = {stop_bit, b, 1'b0};
    t0   = int'(cyc) + 1;
    for (int i = 0; i < 10; i++) begin
      if (slow) rx_slow = bits[i];
      else rx_fast = bits[i];
      repeat (m) @(negedge clk);
    end
    if (slow) rx_slow = 1'b1;
    else rx_fast = 1'b1;
  endtask

  initial begin
    #1500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int         base;
    int         t0;
    int         t1;
    logic [7:0] last_data;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [9:0] bits;
    int unsigned ferr_base;

    // Reset state
    reset_n = 1'b0;
    rx_fast = 1'b1;
    rx_slow = 1'b1;
    #1;
    check("rst_data_fast", 32'(data_fast), 32'h00);
    check("rst_valid_fast", 32'(valid_fast), 32'h0);
    check("rst_data_slow", 32'(data_slow), 32'h00);
    check("rst_valid_slow", 32'(valid_slow), 32'h0);
`ifdef UART_RX_FRAME_ERR_EN
    check("rst_ferr_fast", 32'(ferr_fast), 32'h0);
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Frame 0xA5 with latency window
    base = fq_data.size();
    send_frame(1'b0, 8'hA5, 1'b1, t0);
    repeat (4) @(negedge clk);
    check("a5_count", 32'(fq_data.size()), 32'(base + 1));
    check("a5_data", 32'(fq_at(base)), 32'hA5);
    check("a5_latency", 32'(lat_ok(fc_at(base) - t0, M_FAST)), 32'h1);
    check("a5_hold", 32'(data_fast), 32'hA5);
    last_data = 8'hA5;

    // Short low glitch must be rejected, next frame still received
    base      = fq_data.size();
    ferr_base = ferr_cnt_fast;
    rx_fast = 1'b0;
    repeat (20) @(negedge clk);
    rx_fast = 1'b1;
    repeat (2 * M_FAST) @(negedge clk);
    check("glitch_no_valid", 32'(fq_data.size()), 32'(base));
    check("glitch_no_ferr", ferr_cnt_fast, ferr_base);
    check("glitch_data_kept", 32'(data_fast), 32'(last_data));
    send_frame(1'b0, 8'h3C, 1'b1, t0);
    repeat (4) @(negedge clk);
    check("after_glitch_count", 32'(fq_data.size()), 32'(base + 1));
    check("after_glitch_data", 32'(fq_at(base)), 32'h3C);
    last_data = 8'h3C;

    // Back-to-back frames, no idle gap
    base = fq_data.size();
    send_frame(1'b0, 8'h00, 1'b1, t0);
    send_frame(1'b0, 8'hFF, 1'b1, t1);
    repeat (4) @(negedge clk);
    check("b2b_count", 32'(fq_data.size()), 32'(base + 2));
    check("b2b_first", 32'(fq_at(base)), 32'h00);
    check("b2b_second", 32'(fq_at(base + 1)), 32'hFF);
    check("b2b_lat2", 32'(lat_ok(fc_at(base + 1) - t1, M_FAST)), 32'h1);
    last_data = 8'hFF;

    // Bad stop bit
    base      = fq_data.size();
    ferr_base = ferr_cnt_fast;
    send_frame(1'b0, 8'h5A, 1'b0, t0);
    repeat (2 * M_FAST) @(negedge clk);
`ifdef UART_RX_FRAME_ERR_EN
    check("badstop_no_valid", 32'(fq_data.size()), 32'(base));
    check("badstop_ferr", ferr_cnt_fast, ferr_base + 1);
    check("badstop_data_kept", 32'(data_fast), 32'(last_data));
`else
    check("badstop_count", 32'(fq_data.size()), 32'(base + 1));
    check("badstop_data", 32'(fq_at(base)), 32'h5A);
    last_data = 8'h5A;
`endif

    // Reset in the middle of data bit 4
    base = fq_data.size();
    bits = {1'b1, 8'h96, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx_fast = bits[i];
      repeat (M_FAST) @(negedge clk);
    end
    rx_fast = bits[5];
    repeat (M_FAST / 2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_data", 32'(data_fast), 32'h00);
    check("midrst_valid", 32'(valid_fast), 32'h0);
    rx_fast = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * M_FAST) @(negedge clk);
    check("midrst_no_pulse", 32'(fq_data.size()), 32'(base));
    send_frame(1'b0, 8'hC3, 1'b1, t0);
    repeat (4) @(negedge clk);
    check("midrst_next_count", 32'(fq_data.size()), 32'(base + 1));
    check("midrst_next_data", 32'(fq_at(base)), 32'hC3);

    // Random bytes with random idle gaps against a byte-queue model
    base = fq_data.size();
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(1'b0, b, 1'b1, t0);
      repeat (4) @(negedge clk);
      check("rand_latency", 32'(lat_ok(fc_at(base + k) - t0, M_FAST)), 32'h1);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    repeat (2 * M_FAST) @(negedge clk);
    check("rand_count", 32'(fq_data.size()), 32'(base + 8));
    for (int k = 0; k < 8; k++) begin
      check("rand_data", 32'(fq_at(base + k)), 32'(exp_q[k]));
    end

    // Default baud rate, frame 0x81
    send_frame(1'b1, 8'h81, 1'b1, t0);
    repeat (8) @(negedge clk);
    check("slow_count", 32'(sq_data.size()), 32'h1);
    check("slow_data", 32'(data_slow), 32'h81);
    if (sq_cyc.size() > 0) begin
      check("slow_latency", 32'(lat_ok(sq_cyc[0] - t0, M_SLOW)), 32'h1);
    end else begin
      check("slow_latency", 32'h0, 32'h1);
    end

    check("no_double_valid", dbl_cnt, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: BAUD_CNT_MAX, default 5207, clock cycles per bit (50 MHz / 9600 baud).
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: rx_in  input  1  serial line, asynchronous to clk, idle high.
REQ-005 SHALL have port: rx_data  output  8  last received byte, LSB received first.
REQ-006 SHALL have port: rx_valid  output  1  one-cycle pulse; rx_data is valid in that cycle.
REQ-007 SHALL have port: rx_frame_err  output  1  one-cycle pulse on bad stop bit; present only with UART_RX_FRAME_ERR_EN.

Function
REQ-008 SHALL pass rx_in through a 2-flop synchronizer, then one more register for edge detection; all decisions use the synchronized value.
REQ-009 SHALL implement states IDLE, START, DATA, STOP.
REQ-010 IDLE: on synchronized falling edge (prev=1, cur=0), SHALL go to START and clear baud_cnt to 0.
REQ-011 baud_cnt SHALL be 14 bits; it counts 0..BAUD_CNT_MAX-1 and wraps to 0 while not IDLE; it is held at 0 in IDLE.
REQ-012 The sample point SHALL be the cycle with baud_cnt == BAUD_CNT_MAX/2 (integer division).
REQ-013 START: at the sample point, if line=1 (glitch), SHALL return to IDLE with no output pulse; if line=0, SHALL go to DATA with bit_cnt=0.
REQ-014 DATA: at each sample point SHALL shift the line into a shift register, LSB first, and increment 3-bit bit_cnt; after the 8th sample SHALL go to STOP.
REQ-015 STOP: at the sample point SHALL go to IDLE immediately (mid stop bit), so back-to-back frames are not lost.
REQ-016 Stop sample = 1: in the next cycle, rx_data SHALL load the shift register and rx_valid SHALL pulse for exactly 1 cycle.
REQ-017 rx_data SHALL hold its value until the next valid frame; rx_valid SHALL never be high for 2 consecutive cycles.
REQ-018 Line activity while not IDLE SHALL not restart the frame; a falling edge is detected only in IDLE.

Reset
REQ-019 reset_n low SHALL asynchronously force: state=IDLE, baud_cnt=0, bit_cnt=0, shift register=0, rx_data=8'h00, rx_valid=0, rx_frame_err=0, synchronizer flops=1.
REQ-020 Reset mid-frame SHALL abandon the frame with no pulse; after release, the first complete frame SHALL be received correctly.

Configuration
REQ-021 Macro UART_RX_FRAME_ERR_EN defined: stop sample = 0 SHALL pulse rx_frame_err for 1 cycle (same timing as REQ-016); rx_valid stays low and rx_data is unchanged.
REQ-022 Macro undefined: the rx_frame_err port and its logic SHALL be absent; the stop bit is not checked and every frame produces rx_valid with the received byte.

Structure
REQ-023 Package uart_pkg SHALL hold the rx state encoding (IDLE/START/DATA/STOP), the BAUD_CNT_MAX default, and the data width constant 8.
REQ-024 The synchronizer SHALL be a separate sub-module uart_sync (2-flop, reset value 1); all other logic is in uart_rx.

Verification (run with BAUD_CNT_MAX=56 unless stated)
REQ-025 Frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) -> rx_data=8'hA5 and a single rx_valid pulse within 9.5 bit times +/- 4 cycles of the start edge.
REQ-026 rx_in low for 20 cycles, then high -> no rx_valid and no rx_frame_err; state returns to IDLE; a following 0x3C frame is received as 8'h3C.
REQ-027 Back-to-back 0x00 then 0xFF with no idle gap -> exactly two rx_valid pulses with rx_data 8'h00 then 8'hFF.
REQ-028 0x5A with stop bit=0 -> macro defined: one rx_frame_err pulse, no rx_valid, rx_data unchanged; macro undefined: rx_valid with 8'h5A.
REQ-029 reset_n pulsed low during data bit 4 of a frame -> all outputs 0 immediately, no pulse; the next 0xC3 frame yields rx_data=8'hC3.
REQ-030 BAUD_CNT_MAX=5207, frame 0x81 -> rx_data=8'h81; sampling occurs at baud_cnt=2603 for every bit.
